// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receive stage: gathers n serial bits into a word and
// hands it to a consumer over a valid/ready handshake, flagging dropped words.
module sipo_deserializer #(
  parameter int n         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin_valid,
  input  logic                  serial_in,
  input  logic                  clear,
  output logic [n-1:0]          parallel_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [$clog2(n):0]    bit_cnt
);

  localparam int              CW   = $clog2(n) + 1;
  localparam logic [CW-1:0]   LAST = CW'(n - 1);

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e          state_q;
  logic [n-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    word_q;
  logic            valid_q;
  logic            overrun_q;
  logic            shift_en;
  logic            complete;
  logic            accept;

  // Next shift-register contents; shift_d already includes the current bit,
  // so on completion it is exactly the word to publish.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    shift_en = sin_valid & ~clear;
    complete = shift_en && (cnt_q == LAST);
    accept   = valid_q & out_ready;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sin_valid) begin
      shift_d = MSB_FIRST ? {shift_q[n-2:0], serial_in}
                          : {serial_in, shift_q[n-1:1]};
      cnt_d   = complete ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= EMPTY;
      shift_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      // A fresh overrun below overrides a clear request on the same edge.
      if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        EMPTY: begin
          if (complete) begin
            word_q  <= shift_d;
            valid_q <= 1'b1;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (complete && accept) begin
            word_q  <= shift_d;
          end else if (complete) begin
            overrun_q <= 1'b1;
          end else if (accept) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign parallel_out = word_q;
  assign out_valid    = valid_q;
  assign overrun      = overrun_q;
  assign bit_cnt      = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed loopback, gap, overrun,
// abort and reset scenarios checked against a queue-based reference model.
module tb_sipo_deserializer;

   localparam int N   = 4;
   localparam bit MSB = 1'b1;

   logic            clk;
   logic            rst;
   logic            sinValid;
   logic            serialIn;
   logic            clear;
   logic [N-1:0]    parallelOut;
   logic            outValid;
   logic            outReady;
   logic            overrun;
   logic            overrunClr;
   logic [$clog2(N):0] bitCnt;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Reference model state: received bits of the partial word kept as a queue.
   logic            bitsQ[$];
   logic [N-1:0]    mWord;
   logic            mValid;
   logic            mOverrun;

   sipo_deserializer #(.n(N), .MSB_FIRST(MSB)) dut (
      .clk         (clk),
      .rst         (rst),
      .sin_valid   (sinValid),
      .serial_in   (serialIn),
      .clear       (clear),
      .parallel_out(parallelOut),
      .out_valid   (outValid),
      .out_ready   (outReady),
      .overrun     (overrun),
      .overrun_clr (overrunClr),
      .bit_cnt     (bitCnt)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Assemble a word from received bits in arrival order.
   function automatic logic [N-1:0] buildWord();
      logic [N-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) begin
         if (MSB) w = {w[N-2:0], bitsQ[i]};
         else     w[i] = bitsQ[i];
      end
      return w;
   endfunction

   // Model update at each rising edge from the inputs that edge samples.
   always @(posedge clk) begin
      logic prevValid;
      logic loaded;
      logic [N-1:0] w;
      prevValid = mValid;
      loaded    = 1'b0;
      if (!rst) begin
         bitsQ.delete();
         mWord    = '0;
         mValid   = 1'b0;
         mOverrun = 1'b0;
      end else begin
         if (overrunClr) mOverrun = 1'b0;
         if (clear) begin
            bitsQ.delete();
         end else if (sinValid) begin
            bitsQ.push_back(serialIn);
            if (bitsQ.size() == N) begin
               w = buildWord();
               bitsQ.delete();
               if (!prevValid || outReady) begin
                  mWord  = w;
                  mValid = 1'b1;
                  loaded = 1'b1;
               end else begin
                  mOverrun = 1'b1;
               end
            end
         end
         if (prevValid && outReady && !loaded) mValid = 1'b0;
      end
   end

   // Compare DUT outputs with the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checks += 4;
         if (parallelOut !== mWord) begin
            errors++;
            $display("[TB] FAIL model parallel_out @%0t: got %b expected %b", $time, parallelOut, mWord);
         end
         if (outValid !== mValid) begin
            errors++;
            $display("[TB] FAIL model out_valid @%0t: got %b expected %b", $time, outValid, mValid);
         end
         if (overrun !== mOverrun) begin
            errors++;
            $display("[TB] FAIL model overrun @%0t: got %b expected %b", $time, overrun, mOverrun);
         end
         if (int'(bitCnt) !== bitsQ.size()) begin
            errors++;
            $display("[TB] FAIL model bit_cnt @%0t: got %0d expected %0d", $time, bitCnt, bitsQ.size());
         end
      end
   end

   // Drive one cycle of inputs and advance to the next falling edge.
   task automatic applyStimulus(input logic v, input logic b, input logic rdy,
                                input logic clr, input logic oclr);
      sinValid   = v;
      serialIn   = b;
      outReady   = rdy;
      clear      = clr;
      overrunClr = oclr;
      @(negedge clk);
   endtask

   // Literal expectation check against hand-computed values.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sendWord(input logic [N-1:0] w, input logic rdy);
      for (int i = N - 1; i >= 0; i--) applyStimulus(1'b1, w[i], rdy, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      sinValid = 1'b1; serialIn = 1'b1; outReady = 1'b0; clear = 1'b0; overrunClr = 1'b0;
      checkEn = 1'b1;

      // Reset held two cycles with serial data present.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("reset parallel_out", 32'(parallelOut), 32'h0);
      checkOutput("reset out_valid", 32'(outValid), 32'h0);
      checkOutput("reset bit_cnt", 32'(bitCnt), 32'h0);
      checkOutput("reset overrun", 32'(overrun), 32'h0);
      rst = 1'b1;

      // Loopback words streamed MSB first as the upstream shifter emits them.
      sendWord(4'b1011, 1'b1);
      checkOutput("loop1 out_valid", 32'(outValid), 32'h1);
      checkOutput("loop1 parallel_out", 32'(parallelOut), 32'hB);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("loop1 drained", 32'(outValid), 32'h0);
      sendWord(4'b1100, 1'b1);
      checkOutput("loop2 parallel_out", 32'(parallelOut), 32'hC);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Gapped bits 0,1,1,0 with two idle cycles between them.
      begin
         logic [3:0] gw;
         gw = 4'b0110;
         for (int i = 0; i < N; i++) begin
            checkOutput("gap bit_cnt", 32'(bitCnt), 32'(i));
            checkOutput("gap out_valid low", 32'(outValid), 32'h0);
            applyStimulus(1'b1, gw[N-1-i], 1'b0, 1'b0, 1'b0);
            if (i != N - 1) repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
      checkOutput("gap out_valid", 32'(outValid), 32'h1);
      checkOutput("gap parallel_out", 32'(parallelOut), 32'h6);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Backpressure: second word dropped, then accept and clear the flag.
      sendWord(4'b1011, 1'b0);
      sendWord(4'b0101, 1'b0);
      checkOutput("ovr out_valid", 32'(outValid), 32'h1);
      checkOutput("ovr parallel_out", 32'(parallelOut), 32'hB);
      checkOutput("ovr overrun", 32'(overrun), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("ovr accepted", 32'(outValid), 32'h0);
      checkOutput("ovr sticky", 32'(overrun), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ovr cleared", 32'(overrun), 32'h0);

      // Accept and new-word completion on the same edge.
      sendWord(4'b1011, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("b2b out_valid", 32'(outValid), 32'h1);
      checkOutput("b2b parallel_out", 32'(parallelOut), 32'hE);
      checkOutput("b2b no overrun", 32'(overrun), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Overrun set and clear requested on the same edge: set wins.
      sendWord(4'b0001, 1'b0);
      sendWord(4'b0011, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      sendWord(4'b0111, 1'b0);
      checkOutput("ovr set wins pending", 32'(overrun), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("ovr set wins", 32'(overrun), 32'h1);
      checkOutput("ovr held word", 32'(parallelOut), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Abort with clear after two bits; the clear-cycle bit is ignored.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("clear bit_cnt", 32'(bitCnt), 32'h0);
      sendWord(4'b0010, 1'b0);
      checkOutput("clear parallel_out", 32'(parallelOut), 32'h2);
      checkOutput("clear out_valid", 32'(outValid), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset after three bits discards the partial word.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      checkOutput("rst mid bit_cnt", 32'(bitCnt), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst mid no word", 32'(outValid), 32'h0);
      checkOutput("rst mid restart cnt", 32'(bitCnt), 32'h1);

      // Mixed traffic checked cycle by cycle against the model.
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 49) != 0);
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0));
      end
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
